// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the shared memory port.
// slave = arbiter view, master = CPU/loader/memory side view.
interface mem_port_arbiter_if #(parameter int AW = 8);
  logic          enable;
  logic          dbg_lock;
  // instruction fetch
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic          if_stall;
  // data access
  logic          mem_req;
  logic          mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [15:0]   mem_wdata_i;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic          mem_stall;
  // debug / loader
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [15:0]   dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  // shared return bus and memory macro side
  logic [15:0]   rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;

  modport slave (
    input  enable, dbg_lock,
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_stall,
    input  mem_req, mem_we_i, mem_addr_i, mem_wdata_i,
    output mem_gnt, mem_rvalid, mem_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid,
    output rdata, mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output enable, dbg_lock,
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_stall,
    output mem_req, mem_we_i, mem_addr_i, mem_wdata_i,
    input  mem_gnt, mem_rvalid, mem_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid,
    input  rdata, mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (IF / MEM / DBG) for one single-port synchronous memory.
// Grants and memory command are combinational; read returns are tagged with
// their owner through an RD_LAT-deep pipeline so data comes back to the right
// requester. IF is promoted over MEM after STARVE_MAX consecutive denials.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 3
) (
  input logic             clk,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] OWN_IF  = 2'd0;
  localparam logic [1:0] OWN_MEM = 2'd1;
  localparam logic [1:0] OWN_DBG = 2'd2;

  logic [SW-1:0]               r_starve;
  logic [RD_LAT-1:0]           r_tag_vld;
  logic [RD_LAT-1:0][1:0]      r_tag_own;
  logic [15:0]                 r_rdata;

  logic                        w_if_pri;
  logic                        w_gnt_if, w_gnt_mem, w_gnt_dbg;
  logic                        w_rd_gnt;
  logic [1:0]                  w_own;
  logic                        w_ret_vld;
  logic [1:0]                  w_ret_own;

  assign w_if_pri = (r_starve == SW'(STARVE_MAX));

  // Priority select: lock restricts to DBG; starvation swaps IF above MEM.
  always_comb begin
    w_gnt_if  = 1'b0;
    w_gnt_mem = 1'b0;
    w_gnt_dbg = 1'b0;
    if (bus.enable) begin
      if (bus.dbg_lock)                w_gnt_dbg = bus.dbg_req;
      else if (bus.dbg_req)            w_gnt_dbg = 1'b1;
      else if (w_if_pri && bus.if_req) w_gnt_if  = 1'b1;
      else if (bus.mem_req)            w_gnt_mem = 1'b1;
      else if (bus.if_req)             w_gnt_if  = 1'b1;
    end
  end

  // Memory command mux from the winner; idle command is all zeros.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    w_own         = OWN_IF;
    w_rd_gnt      = 1'b0;
    if (w_gnt_dbg) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dbg_we;
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
      w_own         = OWN_DBG;
      w_rd_gnt      = ~bus.dbg_we;
    end else if (w_gnt_mem) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.mem_we_i;
      bus.mem_addr  = bus.mem_addr_i;
      bus.mem_wdata = bus.mem_wdata_i;
      w_own         = OWN_MEM;
      w_rd_gnt      = ~bus.mem_we_i;
    end else if (w_gnt_if) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.if_addr;
      w_own         = OWN_IF;
      w_rd_gnt      = 1'b1;
    end
  end

  assign bus.if_gnt    = w_gnt_if;
  assign bus.mem_gnt   = w_gnt_mem;
  assign bus.dbg_gnt   = w_gnt_dbg;
  assign bus.if_stall  = bus.if_req  & ~w_gnt_if;
  assign bus.mem_stall = bus.mem_req & ~w_gnt_mem;

  // IF starvation counter: saturating count of denied enabled IF cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          r_starve <= '0;
    else if (bus.enable) begin
      if (!bus.if_req || w_gnt_if)       r_starve <= '0;
      else if (!w_if_pri)                r_starve <= r_starve + SW'(1);
    end
  end

  // Owner tag pipeline: stage RD_LAT-1 lines up with mem_rdata of that read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag_vld <= '0;
      r_tag_own <= '0;
    end else begin
      r_tag_vld[0] <= w_rd_gnt;
      r_tag_own[0] <= w_own;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  assign w_ret_vld = r_tag_vld[RD_LAT-1];
  assign w_ret_own = r_tag_own[RD_LAT-1];

  assign bus.if_rvalid  = w_ret_vld && (w_ret_own == OWN_IF);
  assign bus.mem_rvalid = w_ret_vld && (w_ret_own == OWN_MEM);
  assign bus.dbg_rvalid = w_ret_vld && (w_ret_own == OWN_DBG);

  // Return bus passes mem_rdata on a return and otherwise holds the last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_rdata <= '0;
    else if (w_ret_vld) r_rdata <= bus.mem_rdata;
  end

  assign bus.rdata = w_ret_vld ? bus.mem_rdata : r_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences and a
// random run, all checked each cycle against a queue-based reference model.
module tb_mem_port_arbiter;
  localparam int AW = 8, RD_LAT = 2, SMAX = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW)) bus();

  mem_port_arbiter #(.AW(AW), .RD_LAT(RD_LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { int due; int own; } ret_t;
  typedef struct {
    bit en, lock, ir, mr, mwe, dr, dwe;
    logic [2:0] exp_gnt; // {dbg, mem, if}
  } vec_t;

  int n_vec = 0, n_err = 0, cyc = 0;
  int m_starve = 0;
  ret_t q[$];
  logic [15:0] m_hold = '0;
  logic [2:0]  s_gnt, s_rv;
  logic [15:0] s_rdata;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic idle();
    bus.enable = 1'b1; bus.dbg_lock = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0; bus.mem_wdata_i = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
  endtask

  // One clock: check all outputs mid-cycle against the model, then advance it.
  task automatic cycle();
    int own;
    logic [25:0] e_cmd;
    logic [2:0]  e_rv;
    logic [15:0] e_rd;
    bit rd;
    @(negedge clk);
    own = -1;
    if (bus.enable) begin
      if (bus.dbg_lock)                    begin if (bus.dbg_req) own = 2; end
      else if (bus.dbg_req)                own = 2;
      else if (m_starve == SMAX && bus.if_req) own = 0;
      else if (bus.mem_req)                own = 1;
      else if (bus.if_req)                 own = 0;
    end
    case (own)
      0:       e_cmd = {1'b1, 1'b0, bus.if_addr, 16'h0};
      1:       e_cmd = {1'b1, bus.mem_we_i, bus.mem_addr_i, bus.mem_wdata_i};
      2:       e_cmd = {1'b1, bus.dbg_we, bus.dbg_addr, bus.dbg_wdata};
      default: e_cmd = '0;
    endcase
    s_gnt = {bus.dbg_gnt, bus.mem_gnt, bus.if_gnt};
    chk("gnt", s_gnt, (own < 0) ? 3'b000 : (3'b001 << own));
    chk("stall", {bus.if_stall, bus.mem_stall},
        {bus.if_req && own != 0, bus.mem_req && own != 1});
    chk("cmd", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, e_cmd);
    e_rv = 3'b000;
    e_rd = m_hold;
    if (q.size() > 0 && q[0].due == cyc) begin
      e_rv[q[0].own] = 1'b1;
      e_rd = bus.mem_rdata;
      m_hold = bus.mem_rdata;
      void'(q.pop_front());
    end
    s_rv    = {bus.dbg_rvalid, bus.mem_rvalid, bus.if_rvalid};
    s_rdata = bus.rdata;
    chk("rvalid", s_rv, e_rv);
    chk("rdata", s_rdata, e_rd);
    rd = (own == 0) || (own == 1 && !bus.mem_we_i) || (own == 2 && !bus.dbg_we);
    if (own >= 0 && rd) q.push_back('{cyc + RD_LAT, own});
    if (bus.enable) begin
      if (!bus.if_req || own == 0) m_starve = 0;
      else if (m_starve < SMAX)    m_starve++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Asynchronous reset pulse asserted mid-cycle; in-flight reads are dropped.
  task automatic do_reset();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_rv", {bus.dbg_rvalid, bus.mem_rvalid, bus.if_rvalid}, 3'b000);
    chk("rst_rdata", bus.rdata, 16'h0);
    chk("rst_cmd", {bus.mem_en, bus.if_gnt, bus.mem_gnt, bus.dbg_gnt}, 4'h0);
    q.delete();
    m_starve = 0;
    m_hold = '0;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b1;
  endtask

  vec_t tbl[15];

  initial begin
    //          en lk ir mr mwe dr dwe  gnt
    tbl[0]  = '{1, 0, 1, 0, 0, 0, 0, 3'b001};
    tbl[1]  = '{1, 0, 0, 1, 0, 0, 0, 3'b010};
    tbl[2]  = '{1, 0, 0, 0, 0, 1, 0, 3'b100};
    tbl[3]  = '{1, 0, 1, 1, 1, 0, 0, 3'b010}; // starve 1
    tbl[4]  = '{1, 0, 1, 1, 1, 0, 0, 3'b010}; // starve 2
    tbl[5]  = '{1, 0, 1, 1, 1, 0, 0, 3'b010}; // starve 3
    tbl[6]  = '{1, 0, 1, 1, 1, 0, 0, 3'b001}; // IF promoted
    tbl[7]  = '{1, 0, 1, 1, 0, 1, 1, 3'b100}; // starve 1
    tbl[8]  = '{0, 0, 1, 1, 0, 1, 0, 3'b000}; // holds 1
    tbl[9]  = '{1, 1, 1, 1, 0, 0, 0, 3'b000}; // starve 2
    tbl[10] = '{1, 1, 1, 1, 0, 1, 0, 3'b100}; // starve 3
    tbl[11] = '{1, 1, 1, 1, 0, 1, 1, 3'b100}; // saturated, lock wins
    tbl[12] = '{1, 0, 1, 1, 0, 0, 0, 3'b001}; // lock drops, IF wins
    tbl[13] = '{1, 0, 0, 1, 0, 0, 0, 3'b010};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 3'b000};

    idle();
    bus.mem_rdata = '0;
    #2;
    do_reset();

    // vector table
    for (int i = 0; i < 15; i++) begin
      bus.enable = tbl[i].en; bus.dbg_lock = tbl[i].lock;
      bus.if_req = tbl[i].ir; bus.if_addr = AW'(8'h40 + i);
      bus.mem_req = tbl[i].mr; bus.mem_we_i = tbl[i].mwe;
      bus.mem_addr_i = AW'(8'h80 + i); bus.mem_wdata_i = 16'h1234;
      bus.dbg_req = tbl[i].dr; bus.dbg_we = tbl[i].dwe;
      bus.dbg_addr = AW'(8'hC0 + i); bus.dbg_wdata = 16'hBEEF;
      bus.mem_rdata = 16'($urandom);
      cycle();
      chk("tbl_gnt", s_gnt, tbl[i].exp_gnt);
    end
    idle();
    for (int i = 0; i < 3; i++) cycle();

    // single IF read, data back two cycles later
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 8'h10;
    cycle();
    chk("A_gnt", s_gnt, 3'b001);
    idle(); cycle();
    bus.mem_rdata = 16'hABCD;
    cycle();
    chk("A_rvalid", s_rv, 3'b001);
    chk("A_rdata", s_rdata, 16'hABCD);

    // back-to-back reads by MEM, IF, DBG
    idle(); bus.mem_req = 1'b1; bus.mem_addr_i = 8'h01; cycle();
    idle(); bus.if_req = 1'b1; bus.if_addr = 8'h02; cycle();
    idle(); bus.dbg_req = 1'b1; bus.dbg_addr = 8'h03; bus.mem_rdata = 16'h1111; cycle();
    chk("B_mem_rv", s_rv, 3'b010); chk("B_mem_rd", s_rdata, 16'h1111);
    idle(); bus.mem_rdata = 16'h2222; cycle();
    chk("B_if_rv", s_rv, 3'b001); chk("B_if_rd", s_rdata, 16'h2222);
    bus.mem_rdata = 16'h3333; cycle();
    chk("B_dbg_rv", s_rv, 3'b100); chk("B_dbg_rd", s_rdata, 16'h3333);
    bus.mem_rdata = 16'h0000; cycle();
    chk("B_hold_rv", s_rv, 3'b000); chk("B_hold_rd", s_rdata, 16'h3333);

    // enable drops right after a MEM read grant
    idle(); bus.mem_req = 1'b1; bus.mem_addr_i = 8'h55; cycle();
    chk("C_gnt", s_gnt, 3'b010);
    bus.enable = 1'b0; cycle();
    chk("C_nognt", s_gnt, 3'b000);
    bus.mem_rdata = 16'h5A5A; cycle();
    chk("C_nognt2", s_gnt, 3'b000);
    chk("C_rv", s_rv, 3'b010); chk("C_rd", s_rdata, 16'h5A5A);
    idle(); cycle();

    // reset one cycle after an IF read grant
    bus.if_req = 1'b1; bus.if_addr = 8'h77; cycle();
    chk("D_gnt", s_gnt, 3'b001);
    idle(); cycle();
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 8'h78; bus.mem_rdata = 16'hDEAD; cycle();
    chk("D_rv", s_rv, 3'b000);
    chk("D_gnt2", s_gnt, 3'b001);
    idle(); cycle(); cycle();

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.dbg_lock = ($urandom_range(0, 15) == 0);
      bus.if_req = 1'($urandom); bus.if_addr = AW'($urandom);
      bus.mem_req = 1'($urandom); bus.mem_we_i = 1'($urandom);
      bus.mem_addr_i = AW'($urandom); bus.mem_wdata_i = 16'($urandom);
      bus.dbg_req = ($urandom_range(0, 3) == 0); bus.dbg_we = 1'($urandom);
      bus.dbg_addr = AW'($urandom); bus.dbg_wdata = 16'($urandom);
      bus.mem_rdata = 16'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
